// File: rtl/calc_pkg.sv
// Shared calculator types: key classification, operator codes and the
// keypad row/column to {type, value} map.
package calc_pkg;

  typedef enum logic [1:0] {
    KEY_DIGIT = 2'b00,
    KEY_OP    = 2'b01,
    KEY_EQ    = 2'b10,
    KEY_CLR   = 2'b11
  } key_type_t;

  localparam logic [3:0] OP_ADD      = 4'hA;
  localparam logic [3:0] OP_SUB      = 4'hB;
  localparam logic [3:0] OP_MUL      = 4'hC;
  localparam logic [3:0] OP_DIV      = 4'hD;
  localparam logic [3:0] KEY_CLR_VAL = 4'hE;
  localparam logic [3:0] KEY_EQ_VAL  = 4'hF;

  // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D
  function automatic logic [5:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] km;
    if (col == 2'd3) begin
      km = {KEY_OP, OP_ADD + {2'b00, row}};
    end else if (row != 2'd3) begin
      km = {KEY_DIGIT, 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1)};
    end else if (col == 2'd0) begin
      km = {KEY_CLR, KEY_CLR_VAL};
    end else if (col == 2'd1) begin
      km = {KEY_DIGIT, 4'd0};
    end else begin
      km = {KEY_EQ, KEY_EQ_VAL};
    end
    return km;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce and key decode.
//   state   | meaning
//   SCAN    | rotate rows, sample columns at the end of each dwell
//   DEBOUNCE| rows frozen, count cycles matching the captured column
//   HELD    | keyPress high, count consecutive all-released cycles
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  output logic       keyPress,
  output logic [1:0] keyType,
  output logic [3:0] keyValue
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CYC);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;

  logic [3:0]    cols_s;
  logic [1:0]    state_d, state_q;
  logic [1:0]    row_d, row_q;
  logic [1:0]    col_d, col_q;
  logic [3:0]    rows_d, rows_q;
  logic [3:0]    cap_d, cap_q;
  logic [SW-1:0] scan_cnt_d, scan_cnt_q;
  logic [DW-1:0] deb_cnt_d, deb_cnt_q;
  logic          key_press_d, key_press_q;
  logic [1:0]    key_type_d, key_type_q;
  logic [3:0]    key_value_d, key_value_q;

  logic [3:0]    cols_low;
  logic          one_low;
  logic [1:0]    col_enc;
  logic [DW-1:0] deb_inc;
  logic [5:0]    km;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_col_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (cols),
    .q_o  (cols_s)
  );

  always_comb begin
    cols_low = ~cols_s;
    one_low  = (cols_low != 4'd0) && ((cols_low & (cols_low - 4'd1)) == 4'd0);
    case (cols_low)
      4'b0001: col_enc = 2'd0;
      4'b0010: col_enc = 2'd1;
      4'b0100: col_enc = 2'd2;
      default: col_enc = 2'd3;
    endcase
    deb_inc = (deb_cnt_q == DEB_DONE) ? deb_cnt_q : deb_cnt_q + DW'(1);
    km      = keymap(row_q, col_q);

    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cap_d       = cap_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    key_press_d = key_press_q;
    key_type_d  = key_type_q;
    key_value_d = key_value_q;

    case (state_q)
      ST_SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (one_low) begin
            cap_d     = cols_s;
            col_d     = col_enc;
            deb_cnt_d = '0;
            state_d   = ST_DEB;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SW'(1);
        end
      end
      ST_DEB: begin
        if (cols_s == cap_q) begin
          deb_cnt_d = deb_inc;
          if (deb_inc == DEB_DONE) begin
            key_type_d  = km[5:4];
            key_value_d = km[3:0];
            key_press_d = 1'b1;
            deb_cnt_d   = '0;
            state_d     = ST_HELD;
          end
        end else begin
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
          row_d      = row_q + 2'd1;
          state_d    = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (cols_s == 4'hF) begin
          deb_cnt_d = deb_inc;
          if (deb_inc == DEB_DONE) begin
            key_press_d = 1'b0;
            deb_cnt_d   = '0;
            scan_cnt_d  = '0;
            row_d       = row_q + 2'd1;
            state_d     = ST_SCAN;
          end
        end else begin
          deb_cnt_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    rows_d = ~(4'b0001 << row_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SCAN;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      rows_q      <= 4'b1110;
      cap_q       <= 4'hF;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_press_q <= 1'b0;
      key_type_q  <= 2'b00;
      key_value_q <= 4'h0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      rows_q      <= rows_d;
      cap_q       <= cap_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      key_press_q <= key_press_d;
      key_type_q  <= key_type_d;
      key_value_q <= key_value_d;
    end
  end

  assign rows     = rows_q;
  assign keyPress = key_press_q;
  assign keyType  = key_type_q;
  assign keyValue = key_value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a matrix keypad model driving cols from rows.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       keyPress;
  logic [1:0] keyType;
  logic [3:0] keyValue;
  logic [15:0] pressed = '0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rows    (rows),
    .cols    (cols),
    .keyPress(keyPress),
    .keyType (keyType),
    .keyValue(keyValue)
  );

  always #5 clk = ~clk;

  // a closed switch ties its column to the driven-low row
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
  end

  typedef struct {
    logic [1:0] t;
    logic [3:0] v;
    logic [3:0] rw;
    bit         chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t cur;
  bit   cur_valid = 0;

  function automatic exp_t key_ref(input int r, input int c, input bit chk);
    string map = "123A456B789C*0#D";
    byte   ch;
    exp_t  e;
    ch = map[r*4+c];
    if (ch >= "0" && ch <= "9") begin
      e.t = 2'b00; e.v = 4'(ch - 8'd48);
    end else if (ch >= "A" && ch <= "D") begin
      e.t = 2'b01; e.v = 4'(ch - 8'd65 + 8'd10);
    end else if (ch == "*") begin
      e.t = 2'b11; e.v = 4'hE;
    end else begin
      e.t = 2'b10; e.v = 4'hF;
    end
    e.rw  = ~(4'b0001 << r);
    e.chk = chk;
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor: pops an expectation on every keyPress rising edge
  initial begin
    logic       kp_prev = 1'b0;
    logic [3:0] rows_prev = 4'hF;
    int         last_chg = 0;
    int         last_fall = -100;
    forever begin
      @(negedge clk);
      if (rows !== rows_prev) last_chg = cyc;
      rows_prev = rows;
      if (keyPress === 1'b1 && kp_prev === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_press actual=%0h/%0h required=none", keyType, keyValue);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1;
          check("key_type", int'(keyType), int'(cur.t));
          check("key_value", int'(keyValue), int'(cur.v));
          if (cur.chk) check("press_latency", cyc - last_chg, SD + DC);
          check("low_gap_ok", int'(cyc - last_fall >= SD), 1);
        end
      end
      if (keyPress === 1'b0 && kp_prev === 1'b1) begin
        last_fall = cyc;
        cur_valid = 0;
      end
      if (keyPress === 1'b1 && cur_valid) check("rows_frozen", int'(rows), int'(cur.rw));
      kp_prev = keyPress;
    end
  end

  task automatic wait_kp(input logic lvl, input int bound, input string nm, output int lat);
    lat = 0;
    while (keyPress !== lvl && lat < bound) begin
      @(negedge clk);
      lat++;
    end
    if (keyPress !== lvl) begin
      checks++;
      failures++;
      $display("FAIL %s actual=%b required=%b after %0d cycles", nm, keyPress, lvl, lat);
    end
  endtask

  task automatic release_all(input exp_t e);
    int lat;
    @(negedge clk);
    pressed = '0;
    wait_kp(1'b0, DC + 8, "release_timeout", lat);
    check("release_latency", lat, DC + 2);
    check("type_hold", int'(keyType), int'(e.t));
    check("value_hold", int'(keyValue), int'(e.v));
  endtask

  task automatic press_release(input int r, input int c, input int hold);
    exp_t e;
    int   lat;
    e = key_ref(r, c, 1);
    exp_q.push_back(e);
    @(negedge clk);
    pressed[r*4+c] = 1'b1;
    wait_kp(1'b1, 2 + 4*SD + DC + 4, "press_timeout", lat);
    repeat (hold) @(negedge clk);
    release_all(e);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   nchg;
    logic [3:0] rp;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rows", int'(rows), 'hE);
    check("rst_keypress", int'(keyPress), 0);
    check("rst_type", int'(keyType), 0);
    check("rst_value", int'(keyValue), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset in the middle of a dwell on row 1
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midscan_rst_rows", int'(rows), 'hE);
    check("midscan_rst_keypress", int'(keyPress), 0);
    @(negedge clk);
    rst_n = 1'b1;

    press_release(2, 0, 50);

    // bouncy B
    e = key_ref(1, 3, 1);
    exp_q.push_back(e);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      pressed[1*4+3] = ~pressed[1*4+3];
      repeat (3) @(negedge clk);
    end
    wait_kp(1'b1, 2 + 4*SD + DC + 4, "bounce_press_timeout", lat);
    repeat (20) @(negedge clk);
    release_all(e);

    press_release(3, 0, 20);
    press_release(3, 2, 20);

    // hold 5, then add 9 and 6
    e = key_ref(1, 1, 1);
    exp_q.push_back(e);
    @(negedge clk);
    pressed[1*4+1] = 1'b1;
    wait_kp(1'b1, 2 + 4*SD + DC + 4, "hold5_press_timeout", lat);
    repeat (5) @(negedge clk);
    pressed[2*4+2] = 1'b1;
    pressed[1*4+2] = 1'b1;
    repeat (60) @(negedge clk);
    check("hold5_type", int'(keyType), int'(e.t));
    check("hold5_value", int'(keyValue), int'(e.v));
    release_all(e);

    // 1 and 2 together in row 0
    @(negedge clk);
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    nchg = 0;
    rp = rows;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rows != rp) nchg++;
      rp = rows;
    end
    check("two_key_keypress", int'(keyPress), 0);
    check("two_key_scanning", int'(nchg >= 8), 1);
    @(negedge clk);
    pressed = '0;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      press_release(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(5, 30)));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    // reset while a key is held, then fresh re-detection
    e = key_ref(2, 1, 1);
    exp_q.push_back(e);
    @(negedge clk);
    pressed[2*4+1] = 1'b1;
    wait_kp(1'b1, 2 + 4*SD + DC + 4, "rstpress_timeout", lat);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midpress_rst_keypress", int'(keyPress), 0);
    check("midpress_rst_type", int'(keyType), 0);
    check("midpress_rst_value", int'(keyValue), 0);
    check("midpress_rst_rows", int'(rows), 'hE);
    repeat (2) @(negedge clk);
    e = key_ref(2, 1, 0);
    exp_q.push_back(e);
    rst_n = 1'b1;
    wait_kp(1'b1, 2 + 4*SD + DC + 6, "redetect_timeout", lat);
    repeat (10) @(negedge clk);
    release_all(e);

    repeat (10) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad, synchronises and debounces the column inputs, and presents one decoded key to the calculator Controller. Outputs are a level `keyPress` plus a classified `keyType` and a 4-bit `keyValue`. It sits directly upstream of the Controller, which waits for `keyPress` high, acts on `keyType`, and returns to its wait state when `keyPress` falls.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven (dwell); must be >= 3.
- `DEBOUNCE_CYC`, default 20000: consecutive stable synchronised samples required to accept a press or a release; must be >= 1.
- `clk`  in  1  single system clock; all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rows`  out  4  row drives, active-low, one-hot-zero (exactly one bit low).
- `cols`  in  4  column sense, active-low (board pull-ups), asynchronous to `clk`.
- `keyPress`  out  1  high while a debounced key is held.
- `keyType`  out  2  00 digit, 01 operation, 10 equals, 11 clear.
- `keyValue`  out  4  digit 0-9, op A/B/C/D, clear E, equals F.

## Operation
- Column path: `cols` passes through a 2-flop synchroniser; the FSM sees only `cols_s`.
- Key map (row r, col c): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
  - A, B, C, D are + - x / (type 01, value A-D).
  - `*` is clear (type 11, value E). `#` is equals (type 10, value F).
- FSM states:
  - SCAN
    - `rows` rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every `SCAN_DIV` cycles.
    - `cols_s` is sampled on the last cycle of each dwell.
    - Exactly one column low: capture row/col, freeze `rows`, clear the counter, go to DEBOUNCE.
    - Zero columns low, or two or more low: keep scanning.
  - DEBOUNCE
    - `rows` stays frozen; each cycle, compare `cols_s` with the captured pattern.
    - Match: the counter increments.
    - Mismatch (release, bounce, or a second column in the same row): clear the counter, resume SCAN at the next row.
    - Counter reaches `DEBOUNCE_CYC`: latch `keyType`/`keyValue` from the map, set `keyPress` = 1, go to HELD.
  - HELD
    - `rows` stays frozen; `keyPress` stays 1.
    - Each cycle with `cols_s` = 1111 increments the counter; any cycle with a column low clears it.
    - Counter reaches `DEBOUNCE_CYC`: clear `keyPress`, go to SCAN at the next row.
    - Additional presses in the same row or other rows are ignored; no rollover and no second event.
- `keyType`/`keyValue` change only on entry to HELD. They hold their value after release until the next accepted key.
- Counters saturate and never wrap. Widths are `$clog2(SCAN_DIV)` and `$clog2(DEBOUNCE_CYC+1)`.

## Timing
- Reset values (async assert, sync-safe deassert):
  - `rows` = 1110 (row 0), `keyPress` = 0, `keyType` = 00, `keyValue` = 0.
  - State SCAN; counters 0; synchroniser flops = 1111.
- All outputs are registered; there are no combinational paths from `cols`.
- Press latency is deterministic once detected. `keyPress` rises exactly `DEBOUNCE_CYC` cycles after the SCAN sample that detected the key.
- Total pin-to-`keyPress` latency is at most 2 (sync) + 4*`SCAN_DIV` + `DEBOUNCE_CYC` cycles.
- Release latency: `keyPress` falls `DEBOUNCE_CYC` cycles after the first `cols_s` = 1111 cycle of an uninterrupted release run.
- Minimum low time of `keyPress` is one full row dwell (`SCAN_DIV` cycles) before the next press can be detected. This guarantees the Controller observes `keyPress` = 0.
- Reset mid-press: outputs clear immediately. After reset the held key is re-detected and reported as a fresh press.
- `SCAN_DIV` >= 3 guarantees the dwell-end sample reflects the currently driven row through the 2-flop synchroniser.

## Structure
- Shared package `calc_pkg` holds the following; the Controller and memory block import the same package:
  - enum `key_type_t` (KEY_DIGIT = 2'b00, KEY_OP = 2'b01, KEY_EQ = 2'b10, KEY_CLR = 2'b11);
  - op value constants OP_ADD = 4'hA, OP_SUB = 4'hB, OP_MUL = 4'hC, OP_DIV = 4'hD, KEY_CLR_VAL = 4'hE, KEY_EQ_VAL = 4'hF;
  - function `keymap(row, col)` returning {type, value}.
- Sub-module `sync_2ff` (parameter WIDTH, reset value parameter) for the column synchroniser. The FSM, counters, and map decode live in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV` = 4 and `DEBOUNCE_CYC` = 8, with a bench keypad model that drives `cols` from the current `rows`.
- Reset: `rst_n` low mid-scan -> `rows` = 1110, `keyPress` = 0, `keyType` = 00, `keyValue` = 0 in the same cycle, asynchronously.
- Clean press of `7` (r2, c0) held 50 cycles:
  - `keyPress` rises 8 cycles after the detecting sample, with `keyType` = 00 and `keyValue` = 7;
  - `rows` stays 1011 throughout;
  - `keyPress` falls 8 cycles after release; values hold.
- Bouncy press of `B` (r1, c3): toggle 3 times at 3-cycle intervals, then stable -> exactly one `keyPress` rising edge, `keyType` = 01, `keyValue` = B.
- `*` then `#` in sequence -> two separate presses: {11, E} then {10, F}, with `keyPress` low for >= 4 cycles between them.
- Hold `5`, then also press `9` and `6` -> no change to `keyType`/`keyValue` = {00, 5}, a single `keyPress` pulse, no event for the extra keys.
- Two keys in one row (`1` + `2`) pressed simultaneously from idle -> never accepted; `keyPress` stays 0 and scanning continues.
